draw_command_fetcher: RTL and testbench

Responder side of the draw controller's read/clear/reset handshakes. It walks a command memory through a synchronous-read port and decodes each 18-bit draw command. On `go_read_processor` it presents one command and raises `command_read`, or raises `finished_all` when the list ends. It services `go_reset_data` (rewind) and `go_clear_signal` (drop per-command flags).

---
 rtl/draw_cmd_pkg.sv | 32 +++
 rtl/draw_command_fetcher_if.sv | 30 +++
 rtl/draw_cmd_decode.sv | 23 ++
 rtl/draw_command_fetcher.sv | 145 ++++++++++++++
 tb/tb_draw_command_fetcher.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_cmd_pkg.sv
// Shared draw-command definitions: word layout, opcodes and fetcher state codes.
package draw_cmd_pkg;

    localparam int unsigned CMD_WIDTH = 18;
    localparam int unsigned OP_WIDTH  = 2;
    localparam int unsigned X_WIDTH   = 8;
    localparam int unsigned Y_WIDTH   = 7;

    localparam int unsigned OP_MSB = 17;
    localparam int unsigned OP_LSB = 16;
    localparam int unsigned X_MSB  = 15;
    localparam int unsigned X_LSB  = 8;
    localparam int unsigned RSV_BIT = 7;
    localparam int unsigned Y_MSB  = 6;
    localparam int unsigned Y_LSB  = 0;

    localparam logic [OP_WIDTH-1:0] OP_END  = 2'b00;
    localparam logic [OP_WIDTH-1:0] OP_GATE = 2'b01;
    localparam logic [OP_WIDTH-1:0] OP_WIRE = 2'b10;
    localparam logic [OP_WIDTH-1:0] OP_SKIP = 2'b11;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_READY    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_DECODE   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_CLEAR    = 3'd5,
        ST_FINISHED = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/draw_command_fetcher_if.sv
// Handshake, command-memory and decoded-command bundle between controller and fetcher.
interface draw_command_fetcher_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  go_reset_data;
    logic                  go_read_processor;
    logic                  go_clear_signal;
    logic                  data_reset_done;
    logic                  command_read;
    logic                  finished_all;
    logic                  signals_cleared;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [17:0]           mem_rdata;
    logic [1:0]            cmd_opcode;
    logic [7:0]            cmd_x;
    logic [6:0]            cmd_y;
    logic [ADDR_WIDTH-1:0] cmd_index;

    modport slave (
        input  go_reset_data, go_read_processor, go_clear_signal, mem_rdata,
        output data_reset_done, command_read, finished_all, signals_cleared,
        output mem_addr, cmd_opcode, cmd_x, cmd_y, cmd_index
    );

    modport master (
        output go_reset_data, go_read_processor, go_clear_signal, mem_rdata,
        input  data_reset_done, command_read, finished_all, signals_cleared,
        input  mem_addr, cmd_opcode, cmd_x, cmd_y, cmd_index
    );
endinterface

// File: rtl/draw_cmd_decode.sv
// Combinational field split of one draw-command word; reserved bit 7 is dropped.
module draw_cmd_decode
    import draw_cmd_pkg::*;
(
    input  logic [CMD_WIDTH-1:0] word,
    output logic [OP_WIDTH-1:0]  opcode_c,
    output logic [X_WIDTH-1:0]   x_c,
    output logic [Y_WIDTH-1:0]   y_c,
    output logic                 is_end_c,
    output logic                 is_skip_c
);
    logic unused_rsvd;

    // Field extraction and opcode classification.
    always_comb begin
        opcode_c    = word[OP_MSB:OP_LSB];
        x_c         = word[X_MSB:X_LSB];
        y_c         = word[Y_MSB:Y_LSB];
        is_end_c    = (word[OP_MSB:OP_LSB] == OP_END);
        is_skip_c   = (word[OP_MSB:OP_LSB] == OP_SKIP);
        unused_rsvd = word[RSV_BIT];
    end
endmodule

// File: rtl/draw_command_fetcher.sv
// Draw command fetcher: walks command memory and answers read/clear/rewind handshakes.
// Optional DRAW_CMD_COUNT_EN adds the cmds_issued counter output.
module draw_command_fetcher
    import draw_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned CMD_COUNT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  program_reset,
    draw_command_fetcher_if.slave bus
`ifdef DRAW_CMD_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   cmds_issued
`endif
);
    fetch_state_e          state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  exhausted;
    logic                  ptr_at_max;
    logic                  adv_ptr_c;
    logic                  load_cmd_c;

    logic [OP_WIDTH-1:0]   dec_op_c;
    logic [X_WIDTH-1:0]    dec_x_c;
    logic [Y_WIDTH-1:0]    dec_y_c;
    logic                  dec_end_c;
    logic                  dec_skip_c;

    logic [OP_WIDTH-1:0]   cmd_opcode_q;
    logic [X_WIDTH-1:0]    cmd_x_q;
    logic [Y_WIDTH-1:0]    cmd_y_q;
    logic [ADDR_WIDTH-1:0] cmd_index_q;

    // ptr is stable from WAIT through DECODE, so mem_rdata in DECODE is the word at ptr.
    draw_cmd_decode u_decode (
        .word      (bus.mem_rdata),
        .opcode_c  (dec_op_c),
        .x_c       (dec_x_c),
        .y_c       (dec_y_c),
        .is_end_c  (dec_end_c),
        .is_skip_c (dec_skip_c)
    );

    assign ptr_at_max = (ptr == ADDR_WIDTH'(CMD_COUNT_MAX));

    // State register.
    always_ff @(posedge clk) begin
        if (program_reset) state <= ST_RESET;
        else               state <= state_nxt;
    end

    // Next-state logic; rewind request overrides every state.
    always_comb begin
        state_nxt = state;
        if (bus.go_reset_data) begin
            state_nxt = ST_RESET;
        end else begin
            case (state)
                ST_RESET:    state_nxt = ST_READY;
                ST_READY:    if (bus.go_read_processor)
                                 state_nxt = exhausted ? ST_FINISHED : ST_WAIT;
                ST_WAIT:     state_nxt = ST_DECODE;
                ST_DECODE:   begin
                    if (dec_end_c)       state_nxt = ST_FINISHED;
                    else if (dec_skip_c) state_nxt = ptr_at_max ? ST_FINISHED : ST_WAIT;
                    else                 state_nxt = ST_HOLD;
                end
                ST_HOLD:     if (bus.go_clear_signal) state_nxt = ST_CLEAR;
                ST_CLEAR:    begin
                    if (!bus.go_clear_signal) begin
                        if (bus.go_read_processor)
                            state_nxt = exhausted ? ST_FINISHED : ST_WAIT;
                        else
                            state_nxt = ST_READY;
                    end
                end
                ST_FINISHED: state_nxt = ST_FINISHED;
                default:     state_nxt = ST_RESET;
            endcase
        end
    end

    // Moore handshake flags and datapath strobes.
    always_comb begin
        bus.data_reset_done = 1'b0;
        bus.command_read    = 1'b0;
        bus.signals_cleared = 1'b0;
        bus.finished_all    = 1'b0;
        adv_ptr_c           = 1'b0;
        load_cmd_c          = 1'b0;
        case (state)
            ST_RESET:    bus.data_reset_done = 1'b1;
            ST_HOLD:     bus.command_read    = 1'b1;
            ST_CLEAR:    bus.signals_cleared = 1'b1;
            ST_FINISHED: bus.finished_all    = 1'b1;
            ST_DECODE:   begin
                adv_ptr_c  = !bus.go_reset_data && !dec_end_c;
                load_cmd_c = !bus.go_reset_data && !dec_end_c && !dec_skip_c;
            end
            default:     ;
        endcase
    end

    // Pointer, exhaust flag and presented-command registers; pointer saturates at the last slot.
    always_ff @(posedge clk) begin
        if (program_reset) begin
            ptr          <= '0;
            exhausted    <= 1'b0;
            cmd_opcode_q <= '0;
            cmd_x_q      <= '0;
            cmd_y_q      <= '0;
            cmd_index_q  <= '0;
        end else if (bus.go_reset_data) begin
            ptr       <= '0;
            exhausted <= 1'b0;
        end else begin
            if (load_cmd_c) begin
                cmd_opcode_q <= dec_op_c;
                cmd_x_q      <= dec_x_c;
                cmd_y_q      <= dec_y_c;
                cmd_index_q  <= ptr;
            end
            if (adv_ptr_c) begin
                if (ptr_at_max) exhausted <= 1'b1;
                else            ptr       <= ptr + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef DRAW_CMD_COUNT_EN
    // Count of commands presented since the last reset or rewind.
    always_ff @(posedge clk) begin
        if (program_reset || bus.go_reset_data) cmds_issued <= '0;
        else if (load_cmd_c)                    cmds_issued <= cmds_issued + (ADDR_WIDTH+1)'(1);
    end
`endif

    assign bus.mem_addr   = ptr;
    assign bus.cmd_opcode = cmd_opcode_q;
    assign bus.cmd_x      = cmd_x_q;
    assign bus.cmd_y      = cmd_y_q;
    assign bus.cmd_index  = cmd_index_q;

endmodule

// File: tb/tb_draw_command_fetcher.sv
// Directed bench for draw_command_fetcher; dut2 runs with CMD_COUNT_MAX=2 for exhaust checks.
module tb_draw_command_fetcher;
    import draw_cmd_pkg::*;

    logic clk;
    logic program_reset;
    int   checks;
    int   failures;
    int   onehot_errs;
    int   max_addr2;

    logic [17:0] mem1 [256];
    logic [17:0] mem2 [256];

    draw_command_fetcher_if #(.ADDR_WIDTH(8)) ifc ();
    draw_command_fetcher_if #(.ADDR_WIDTH(8)) ifc2 ();

`ifdef DRAW_CMD_COUNT_EN
    logic [8:0] cnt1;
    logic [8:0] cnt2;
`endif

    draw_command_fetcher #(.ADDR_WIDTH(8), .CMD_COUNT_MAX(255)) dut1 (
        .clk           (clk),
        .program_reset (program_reset),
        .bus           (ifc)
`ifdef DRAW_CMD_COUNT_EN
        ,
        .cmds_issued   (cnt1)
`endif
    );

    draw_command_fetcher #(.ADDR_WIDTH(8), .CMD_COUNT_MAX(2)) dut2 (
        .clk           (clk),
        .program_reset (program_reset),
        .bus           (ifc2)
`ifdef DRAW_CMD_COUNT_EN
        ,
        .cmds_issued   (cnt2)
`endif
    );

    assign ifc2.go_reset_data     = ifc.go_reset_data;
    assign ifc2.go_read_processor = ifc.go_read_processor;
    assign ifc2.go_clear_signal   = ifc.go_clear_signal;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read command memories.
    always @(posedge clk) begin
        ifc.mem_rdata  <= mem1[ifc.mem_addr];
        ifc2.mem_rdata <= mem2[ifc2.mem_addr];
    end

    // Flag exclusivity and dut2 address ceiling, watched every cycle.
    always @(negedge clk) begin
        if (!program_reset) begin
            if (32'(ifc.data_reset_done) + 32'(ifc.command_read) + 32'(ifc.finished_all)
                + 32'(ifc.signals_cleared) > 1)
                onehot_errs <= onehot_errs + 1;
            if (32'(ifc2.data_reset_done) + 32'(ifc2.command_read) + 32'(ifc2.finished_all)
                + 32'(ifc2.signals_cleared) > 1)
                onehot_errs <= onehot_errs + 1;
            if (32'(ifc2.mem_addr) > max_addr2) max_addr2 <= 32'(ifc2.mem_addr);
        end
    end

    function automatic logic [17:0] mk(input logic [1:0] op, input logic [7:0] x,
                                       input logic [6:0] y, input logic rsv);
        mk = {op, x, rsv, y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        onehot_errs = 0;
        max_addr2   = 0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = mk(OP_END, 8'd0, 7'd0, 1'b0);
            mem2[i] = mk(OP_END, 8'd0, 7'd0, 1'b0);
        end
        mem1[0] = mk(OP_GATE, 8'd10, 7'd5, 1'b1);
        mem2[0] = mk(OP_GATE, 8'd10, 7'd5, 1'b1);
        ifc.go_reset_data     = 1'b0;
        ifc.go_read_processor = 1'b0;
        ifc.go_clear_signal   = 1'b0;
        program_reset         = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_done",     32'(ifc.data_reset_done), 1);
        chk("rst_cmd_read", 32'(ifc.command_read),    0);
        chk("rst_finished", 32'(ifc.finished_all),    0);
        chk("rst_cleared",  32'(ifc.signals_cleared), 0);
        chk("rst_addr",     32'(ifc.mem_addr),        0);
        chk("rst_opcode",   32'(ifc.cmd_opcode),      0);
        program_reset = 1'b0;

        // GATE at slot 0, three-cycle latency
        ifc.go_reset_data = 1'b1;
        step();
        chk("rewind_done", 32'(ifc.data_reset_done), 1);
        ifc.go_reset_data = 1'b0;
        step();
        chk("ready_idle", 32'(ifc.data_reset_done), 0);
        ifc.go_read_processor = 1'b1;
        step();
        chk("lat_k1", 32'(ifc.command_read), 0);
        step();
        chk("lat_k2", 32'(ifc.command_read), 0);
        step();
        chk("lat_k3",     32'(ifc.command_read), 1);
        chk("gate_op",    32'(ifc.cmd_opcode),   1);
        chk("gate_x",     32'(ifc.cmd_x),        10);
        chk("gate_y",     32'(ifc.cmd_y),        5);
        chk("gate_index", 32'(ifc.cmd_index),    0);
        chk("gate_ptr",   32'(ifc.mem_addr),     1);
        step();
        chk("hold_ignores_read", 32'(ifc.command_read), 1);

        // Clear, then read END
        ifc.go_read_processor = 1'b0;
        ifc.go_clear_signal   = 1'b1;
        step();
        chk("clear_flag",   32'(ifc.signals_cleared), 1);
        chk("clear_no_cmd", 32'(ifc.command_read),    0);
        step();
        chk("clear_held", 32'(ifc.signals_cleared), 1);
        ifc.go_clear_signal = 1'b0;
        step();
        chk("clear_drop", 32'(ifc.signals_cleared), 0);
        ifc.go_read_processor = 1'b1;
        step();
        step();
        step();
        chk("end_finished", 32'(ifc.finished_all), 1);
        chk("end_ptr",      32'(ifc.mem_addr),     1);
        chk("end_x_stable", 32'(ifc.cmd_x),        10);
        ifc.go_read_processor = 1'b0;
        ifc.go_clear_signal   = 1'b1;
        step();
        chk("finished_sticky", 32'(ifc.finished_all), 1);
        ifc.go_clear_signal = 1'b0;

        // SKIP, SKIP, WIRE
        mem1[0] = mk(OP_SKIP, 8'd0, 7'd0, 1'b0);
        mem1[1] = mk(OP_SKIP, 8'd0, 7'd0, 1'b0);
        mem1[2] = mk(OP_WIRE, 8'd200, 7'd119, 1'b0);
        mem2[0] = mem1[0];
        mem2[1] = mem1[1];
        mem2[2] = mem1[2];
        ifc.go_reset_data = 1'b1;
        step();
        chk("rewind2_done", 32'(ifc.data_reset_done), 1);
        chk("rewind2_addr", 32'(ifc.mem_addr),        0);
        ifc.go_reset_data = 1'b0;
        step();
        ifc.go_read_processor = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("skip_lat_k6", 32'(ifc.command_read), 0);
        step();
        chk("skip_lat_k7", 32'(ifc.command_read), 1);
        chk("wire_op",     32'(ifc.cmd_opcode),   2);
        chk("wire_index",  32'(ifc.cmd_index),    2);
        chk("wire_x",      32'(ifc.cmd_x),        200);
        chk("wire_y",      32'(ifc.cmd_y),        119);

        // Rewind during HOLD and during WAIT
        ifc.go_read_processor = 1'b0;
        ifc.go_reset_data     = 1'b1;
        mem1[0] = mk(OP_GATE, 8'd33, 7'd44, 1'b0);
        mem2[0] = mem1[0];
        step();
        chk("hold_rst_done", 32'(ifc.data_reset_done), 1);
        chk("hold_rst_cmd",  32'(ifc.command_read),    0);
        chk("hold_rst_addr", 32'(ifc.mem_addr),        0);
        ifc.go_reset_data = 1'b0;
        step();
        ifc.go_read_processor = 1'b1;
        step();
        ifc.go_read_processor = 1'b0;
        ifc.go_reset_data     = 1'b1;
        step();
        chk("wait_rst_done", 32'(ifc.data_reset_done), 1);
        chk("wait_rst_cmd",  32'(ifc.command_read),    0);
        chk("wait_rst_addr", 32'(ifc.mem_addr),        0);
        ifc.go_reset_data = 1'b0;
        step();
        ifc.go_read_processor = 1'b1;
        step();
        step();
        step();
        chk("after_rst_cmd",   32'(ifc.command_read), 1);
        chk("after_rst_index", 32'(ifc.cmd_index),    0);
        chk("after_rst_x",     32'(ifc.cmd_x),        33);

        // Exhaust on dut2 (last slot 2)
        for (int i = 0; i < 4; i++) begin
            mem1[i] = mk(OP_WIRE, 8'(i + 1), 7'(i + 1), 1'b0);
            mem2[i] = mem1[i];
        end
        ifc.go_read_processor = 1'b0;
        ifc.go_reset_data     = 1'b1;
        step();
        ifc.go_reset_data = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            ifc.go_read_processor = 1'b1;
            step();
            step();
            step();
            chk("exh_cmd_read", 32'(ifc2.command_read), 1);
            chk("exh_index",    32'(ifc2.cmd_index),    i);
            chk("exh_x",        32'(ifc2.cmd_x),        i + 1);
`ifdef DRAW_CMD_COUNT_EN
            chk("cnt_issued", 32'(cnt1), i + 1);
`endif
            ifc.go_read_processor = 1'b0;
            ifc.go_clear_signal   = 1'b1;
            step();
            ifc.go_clear_signal = 1'b0;
            step();
        end
        chk("exh_addr_hold", 32'(ifc2.mem_addr), 2);
        ifc.go_read_processor = 1'b1;
        step();
        chk("exh_finished_direct", 32'(ifc2.finished_all), 1);
        chk("exh_max_addr",        32'(max_addr2),         2);
        ifc.go_read_processor = 1'b0;
        ifc.go_reset_data     = 1'b1;
        step();
        chk("exh_rewind_done", 32'(ifc2.data_reset_done), 1);
        chk("exh_rewind_addr", 32'(ifc2.mem_addr),        0);
`ifdef DRAW_CMD_COUNT_EN
        chk("cnt_cleared", 32'(cnt1), 0);
`endif
        ifc.go_reset_data = 1'b0;
        step();

        chk("flags_onehot", 32'(onehot_errs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
